// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: instruction classes, ALU function codes, FSM states.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_ALU  = 4'h3;
    localparam logic [3:0] OP_OUT  = 4'h4;
    localparam logic [3:0] OP_SWAP = 4'h5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_NOT = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    typedef enum logic [1:0] {
        StFetch,
        StImm,
        StExec,
        StOutWait
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Byte-stream, output-stream and ALU-operand bundle between the sequencer and its surroundings.
interface alu_sequencer_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic       alu_c2;
    logic       alu_c1;
    logic       alu_c0;
    logic [7:0] alu_f;
    logic       zero;
    logic       err;
    logic       busy;

    modport master (
        input  in_data, in_valid, out_ready, alu_f,
        output in_ready, out_data, out_valid, alu_x, alu_y, alu_c2, alu_c1, alu_c0,
               zero, err, busy
    );

    modport slave (
        output in_data, in_valid, out_ready, alu_f,
        input  in_ready, out_data, out_valid, alu_x, alu_y, alu_c2, alu_c1, alu_c0,
               zero, err, busy
    );

endinterface

// File: rtl/alu_out_reg.sv
// Single-entry output holding register: data and valid stay put until the consumer takes them.
module alu_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o
);

    logic [7:0] data_q;
    logic       valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= load_data_i;
            valid_q <= 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator controller: fetches instruction bytes, drives the external ALU, writes back ACC
// and streams ACC snapshots out through a one-entry holding register.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter logic [7:0] ACC_RST  = 8'h00,
    parameter bit         ERR_HALT = 1'b0
) (
    input logic             clk,
    input logic             rst,
    alu_sequencer_if.master bus
);

    state_e     state_q;
    logic [7:0] acc_q;
    logic [7:0] b_q;
    logic [2:0] alu_c_q;
    logic       zero_q;
    logic       err_q;
    logic       imm_b_q;

    logic [3:0] op;
    logic       in_ready;
    logic       in_fire;
    logic       out_load;
    logic       out_fire;
    logic [7:0] out_data;
    logic       out_valid;

    assign op = bus.in_data[7:4];

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            StFetch: in_ready = !(err_q && ERR_HALT);
            StImm:   in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    assign in_fire  = bus.in_valid && in_ready;
    assign out_load = in_fire && (state_q == StFetch) && (op == OP_OUT);
    assign out_fire = out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            acc_q   <= ACC_RST;
            b_q     <= ACC_RST;
            alu_c_q <= ALU_ADD;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            imm_b_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch: begin
                    if (in_fire) begin
                        case (op)
                            OP_NOP: ;
                            OP_LDA: begin
                                imm_b_q <= 1'b0;
                                state_q <= StImm;
                            end
                            OP_LDB: begin
                                imm_b_q <= 1'b1;
                                state_q <= StImm;
                            end
                            OP_ALU: begin
                                alu_c_q <= bus.in_data[2:0];
                                state_q <= StExec;
                            end
                            OP_OUT:  state_q <= StOutWait;
                            OP_SWAP: begin
                                acc_q <= b_q;
                                b_q   <= acc_q;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                StImm: begin
                    if (in_fire) begin
                        if (imm_b_q) b_q <= bus.in_data;
                        else         acc_q <= bus.in_data;
                        state_q <= StFetch;
                    end
                end
                StExec: begin
                    acc_q   <= bus.alu_f;
                    zero_q  <= (bus.alu_f == 8'h00);
                    alu_c_q <= ALU_ADD;
                    state_q <= StFetch;
                end
                StOutWait: begin
                    if (out_fire) state_q <= StFetch;
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    alu_out_reg u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (out_load),
        .load_data_i (acc_q),
        .out_ready_i (bus.out_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.alu_x     = acc_q;
    assign bus.alu_y     = b_q;
    assign bus.alu_c2    = alu_c_q[2];
    assign bus.alu_c1    = alu_c_q[1];
    assign bus.alu_c0    = alu_c_q[0];
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != StFetch);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: table of ALU programs plus hand-written multi-cycle sequences.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_sequencer_if bus ();
    alu_sequencer_if hbus ();

    alu_sequencer #(.ACC_RST(8'h00), .ERR_HALT(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_sequencer #(.ACC_RST(8'h5A), .ERR_HALT(1'b1)) dut_h (
        .clk (clk),
        .rst (rst),
        .bus (hbus)
    );

    // Reference ALU sitting at the parent level; undefined codes return 0.
    function automatic logic [7:0] alu_ref(logic [7:0] x, logic [7:0] y, logic [2:0] c);
        case (c)
            ALU_ADD: return x + y;
            ALU_SUB: return x - y;
            ALU_NOT: return ~x;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_XOR: return x ^ y;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_f  = alu_ref(bus.alu_x, bus.alu_y, {bus.alu_c2, bus.alu_c1, bus.alu_c0});
    assign hbus.alu_f = alu_ref(hbus.alu_x, hbus.alu_y, {hbus.alu_c2, hbus.alu_c1, hbus.alu_c0});

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready === 1'b1) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("send_accepted", {7'd0, ok}, 8'd1);
    endtask

    task automatic wait_out(output logic [7:0] d);
        logic ok;
        ok = 1'b0;
        d  = 8'hxx;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid === 1'b1) begin
                ok = 1'b1;
                d  = bus.out_data;
                break;
            end
            step();
        end
        check("out_valid_seen", {7'd0, ok}, 8'd1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] alu_byte;
        logic [7:0] exp_out;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[10];
    logic [7:0] d;
    logic [7:0] held;

    initial begin
        vecs[0] = '{8'h05, 8'h03, 8'h30, 8'h08, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'h31, 8'hFE, 1'b0};
        vecs[2] = '{8'hAA, 8'h00, 8'h34, 8'h55, 1'b0};
        vecs[3] = '{8'h0F, 8'hF0, 8'h35, 8'h00, 1'b1};
        vecs[4] = '{8'h0F, 8'hF0, 8'h36, 8'hFF, 1'b0};
        vecs[5] = '{8'h3C, 8'h05, 8'h37, 8'h39, 1'b0};
        vecs[6] = '{8'hFF, 8'h01, 8'h30, 8'h00, 1'b1};
        vecs[7] = '{8'h12, 8'h34, 8'h3A, 8'h00, 1'b1};
        vecs[8] = '{8'h55, 8'h55, 8'h3B, 8'h00, 1'b1};
        vecs[9] = '{8'h80, 8'h01, 8'h39, 8'h7F, 1'b0};

        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        hbus.in_data   = 8'h00;
        hbus.in_valid  = 1'b0;
        hbus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_zero", {7'd0, bus.zero}, 8'd0);
        check("rst_err", {7'd0, bus.err}, 8'd0);
        check("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        check("rst_busy", {7'd0, bus.busy}, 8'd0);
        check("rst_alu_c", {5'd0, bus.alu_c2, bus.alu_c1, bus.alu_c0}, 8'd0);
        check("rst_acc", bus.alu_x, 8'h00);
        check("rst_acc_h", hbus.alu_x, 8'h5A);
        check("rst_b_h", hbus.alu_y, 8'h5A);

        // Table: LDA a, LDB b, ALU op, OUT
        foreach (vecs[i]) begin
            send(8'h10);
            send(vecs[i].a);
            send(8'h20);
            send(vecs[i].b);
            send(vecs[i].alu_byte);
            send(8'h40);
            wait_out(d);
            check($sformatf("vec%0d_out", i), d, vecs[i].exp_out);
            check($sformatf("vec%0d_zero", i), {7'd0, bus.zero}, {7'd0, vecs[i].exp_zero});
            step();
            check($sformatf("vec%0d_out_clr", i), {7'd0, bus.out_valid}, 8'd0);
        end

        // EXEC timing: SUB then XOR on the result
        send(8'h10);
        send(8'h03);
        send(8'h20);
        send(8'h05);
        send(8'h31);
        check("exec_alu_c", {5'd0, bus.alu_c2, bus.alu_c1, bus.alu_c0}, 8'd1);
        check("exec_in_ready", {7'd0, bus.in_ready}, 8'd0);
        check("exec_busy", {7'd0, bus.busy}, 8'd1);
        step();
        check("exec_acc", bus.alu_x, 8'hFE);
        check("exec_alu_c_clr", {5'd0, bus.alu_c2, bus.alu_c1, bus.alu_c0}, 8'd0);
        check("exec_ready_back", {7'd0, bus.in_ready}, 8'd1);
        send(8'h37);
        step();
        check("xor_acc", bus.alu_x, 8'hFB);

        // NOT then undefined code 010
        send(8'h10);
        send(8'hAA);
        send(8'h34);
        step();
        check("not_acc", bus.alu_x, 8'h55);
        send(8'h32);
        step();
        check("undef_acc", bus.alu_x, 8'h00);
        check("undef_zero", {7'd0, bus.zero}, 8'd1);
        check("undef_err", {7'd0, bus.err}, 8'd0);

        // LDA/LDB/SWAP leave zero alone
        send(8'h10);
        send(8'h11);
        send(8'h20);
        send(8'h22);
        send(8'h50);
        check("swap_acc", bus.alu_x, 8'h22);
        check("swap_b", bus.alu_y, 8'h11);
        check("swap_zero_kept", {7'd0, bus.zero}, 8'd1);

        // OUT under back-pressure for 3 cycles
        bus.out_ready = 1'b0;
        send(8'h40);
        held = bus.out_data;
        check("bp_data", held, 8'h22);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_valid%0d", c), {7'd0, bus.out_valid}, 8'd1);
            check($sformatf("bp_data%0d", c), bus.out_data, 8'h22);
            check($sformatf("bp_in_ready%0d", c), {7'd0, bus.in_ready}, 8'd0);
            if (c < 2) step();
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_valid_clr", {7'd0, bus.out_valid}, 8'd0);
        check("bp_ready_back", {7'd0, bus.in_ready}, 8'd1);

        // Illegal byte without halt
        send(8'h9A);
        check("ill_err", {7'd0, bus.err}, 8'd1);
        check("ill_in_ready", {7'd0, bus.in_ready}, 8'd1);
        send(8'h10);
        send(8'h42);
        check("ill_lda", bus.alu_x, 8'h42);
        check("ill_err_sticky", {7'd0, bus.err}, 8'd1);

        // Reset while waiting for an immediate
        send(8'h1F);
        check("imm_busy", {7'd0, bus.busy}, 8'd1);
        #2 rst = 1'b1;
        #2;
        check("midrst_acc", bus.alu_x, 8'h00);
        check("midrst_busy", {7'd0, bus.busy}, 8'd0);
        check("midrst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check("midrst_err", {7'd0, bus.err}, 8'd0);
        rst = 1'b0;
        step();
        send(8'h20);
        send(8'h77);
        check("post_rst_b", bus.alu_y, 8'h77);
        check("post_rst_acc", bus.alu_x, 8'h00);

        // Reset discards a pending OUT
        bus.out_ready = 1'b0;
        send(8'h40);
        check("pend_out_valid", {7'd0, bus.out_valid}, 8'd1);
        #2 rst = 1'b1;
        #2;
        check("pend_out_dropped", {7'd0, bus.out_valid}, 8'd0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();

        // Halting variant
        hbus.in_data  = 8'h9A;
        hbus.in_valid = 1'b1;
        step();
        hbus.in_data = 8'h10;
        check("halt_err", {7'd0, hbus.err}, 8'd1);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("halt_in_ready%0d", c), {7'd0, hbus.in_ready}, 8'd0);
            step();
        end
        check("halt_busy", {7'd0, hbus.busy}, 8'd0);
        hbus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("halt_rst_err", {7'd0, hbus.err}, 8'd0);
        check("halt_rst_ready", {7'd0, hbus.in_ready}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
